// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared types and constants for the UART command parser.
// Checksum byte support is selected with UART_CMD_CHECKSUM_EN.
package uart_cmd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t ADDR  = 3'd1;
  localparam state_t DATA  = 3'd2;
  localparam state_t CSUM  = 3'd3;
  localparam state_t ISSUE = 3'd4;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_CSUM    = 2'd0;
  localparam err_code_t ERR_BADCMD  = 2'd1;
  localparam err_code_t ERR_TIMEOUT = 2'd2;
  localparam err_code_t ERR_OVERRUN = 2'd3;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

endpackage

// File: rtl/uart_byte_strobe.sv
// uart_byte_strobe: one-cycle strobe on each rising edge of rx_finish.
// Edge register resets high so a flag held across reset release is ignored.
module uart_byte_strobe (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_finish,
  input  logic [7:0] rx_data,
  output logic       strobe,
  output logic [7:0] byte_data
);

  logic finish_q;

  always_ff @(posedge clk) begin
    if (!rst_n) finish_q <= 1'b1;
    else        finish_q <= rx_finish;
  end

  assign strobe    = rx_finish & ~finish_q;
  assign byte_data = rx_data;

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles SDRAM read/write requests from UART bytes.
// Define UART_CMD_CHECKSUM_EN for a trailing XOR checksum byte per packet.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_BYTES     = 3,
  parameter int DATA_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_finish,
  input  logic [7:0]              rx_data,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_write,
  output logic [ADDR_BYTES*8-1:0] req_addr,
  output logic [DATA_BYTES*8-1:0] req_wdata,
  output logic                    err_valid,
  output logic [1:0]              err_code
);

  localparam int AW   = ADDR_BYTES * 8;
  localparam int DW   = DATA_BYTES * 8;
  localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] ALAST = CW'(ADDR_BYTES - 1);
  localparam logic [CW-1:0] DLAST = CW'(DATA_BYTES - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);

`ifdef UART_CMD_CHECKSUM_EN
  localparam state_t TAIL = CSUM;
`else
  localparam state_t TAIL = ISSUE;
`endif

  logic          strobe;
  logic [7:0]    byte_data;
  state_t        state;
  logic [CW-1:0] byte_cnt;
  logic [TW-1:0] idle_cnt;
  logic          timed;
  logic          timeout;

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0] csum;
`endif

  uart_byte_strobe u_strobe (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_finish (rx_finish),
    .rx_data   (rx_data),
    .strobe    (strobe),
    .byte_data (byte_data)
  );

  assign timed     = (state == ADDR) || (state == DATA) || (state == CSUM);
  assign timeout   = timed && !strobe && (idle_cnt == TLAST);
  assign req_valid = (state == ISSUE);

  // Idle counter only runs mid-packet; it saturates at the limit.
  always_ff @(posedge clk) begin
    if (!rst_n || strobe || !timed) idle_cnt <= '0;
    else if (idle_cnt != TMAX)      idle_cnt <= idle_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      err_valid <= 1'b0;
      err_code  <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      err_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (strobe) begin
            byte_cnt <= '0;
            if (byte_data == CMD_WRITE || byte_data == CMD_READ) begin
              req_write <= (byte_data == CMD_WRITE);
              state     <= ADDR;
`ifdef UART_CMD_CHECKSUM_EN
              csum      <= byte_data;
`endif
            end else begin
              err_valid <= 1'b1;
              err_code  <= ERR_BADCMD;
            end
          end
        end
        ADDR: begin
          if (strobe) begin
            req_addr <= (req_addr << 8) | AW'(byte_data);
`ifdef UART_CMD_CHECKSUM_EN
            csum     <= csum ^ byte_data;
`endif
            if (byte_cnt == ALAST) begin
              byte_cnt <= '0;
              state    <= req_write ? DATA : TAIL;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (timeout) begin
            state     <= IDLE;
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end
        end
        DATA: begin
          if (strobe) begin
            req_wdata <= (req_wdata << 8) | DW'(byte_data);
`ifdef UART_CMD_CHECKSUM_EN
            csum      <= csum ^ byte_data;
`endif
            if (byte_cnt == DLAST) begin
              byte_cnt <= '0;
              state    <= TAIL;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (timeout) begin
            state     <= IDLE;
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end
        end
`ifdef UART_CMD_CHECKSUM_EN
        CSUM: begin
          if (strobe) begin
            if (byte_data == csum) begin
              state <= ISSUE;
            end else begin
              state     <= IDLE;
              err_valid <= 1'b1;
              err_code  <= ERR_CSUM;
            end
          end else if (timeout) begin
            state     <= IDLE;
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end
        end
`endif
        ISSUE: begin
          // A byte arriving while a request is pending is dropped.
          if (strobe) begin
            err_valid <= 1'b1;
            err_code  <= ERR_OVERRUN;
          end
          if (req_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: randomized and directed packets against a packet-level
// model; a negedge monitor scores requests and error pulses from queues.
module tb_uart_cmd_parser;

  localparam int AB = 3;
  localparam int DB = 2;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_finish = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          req_ready = 1'b0;
  logic          req_valid;
  logic          req_write;
  logic [23:0]   req_addr;
  logic [15:0]   req_wdata;
  logic          err_valid;
  logic [1:0]    err_code;

  typedef struct packed {
    logic        w;
    logic [23:0] a;
    logic [15:0] d;
  } req_t;

  typedef logic [7:0] bq_t[$];

  req_t        exp_req[$];
  logic [1:0]  exp_err[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          vcnt = 0;
  logic        rand_ready = 1'b0;
  logic [15:0] last_wdata = '0;

  uart_cmd_parser #(
    .ADDR_BYTES     (AB),
    .DATA_BYTES     (DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_finish (rx_finish),
    .rx_data   (rx_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .err_valid (err_valid),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string name, input logic [63:0] act,
                          input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  req_t prev_req;
  logic prev_hold = 1'b0;

  always @(negedge clk) begin
    req_t cur;
    req_t e;
    logic [1:0] ec;
    cur = {req_write, req_addr, req_wdata};
    if (req_valid) vcnt++;
    if (prev_hold && req_valid) check_eq("req_stable", cur, prev_req);
    prev_hold = req_valid && !req_ready;
    prev_req = cur;
    if (req_valid && req_ready) begin
      check_eq("req_expected", exp_req.size() != 0, 1);
      if (exp_req.size() != 0) begin
        e = exp_req.pop_front();
        check_eq("req_fields", cur, e);
      end
    end
    if (err_valid) begin
      check_eq("err_expected", exp_err.size() != 0, 1);
      if (exp_err.size() != 0) begin
        ec = exp_err.pop_front();
        check_eq("err_code", err_code, ec);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) req_ready = 1'($urandom_range(0, 1));
    end
  end

  function automatic bq_t mk(input logic w, input logic [23:0] a,
                             input logic [15:0] d);
    bq_t q;
    q.push_back(w ? 8'h57 : 8'h52);
    for (int i = AB - 1; i >= 0; i--) q.push_back(a[i*8 +: 8]);
    if (w) for (int i = DB - 1; i >= 0; i--) q.push_back(d[i*8 +: 8]);
`ifdef UART_CMD_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = '0;
      foreach (q[i]) x ^= q[i];
      q.push_back(x);
    end
`endif
    return q;
  endfunction

  task automatic push_req(input logic w, input logic [23:0] a,
                          input logic [15:0] d);
    req_t e;
    if (w) last_wdata = d;
    e.w = w;
    e.a = a;
    e.d = last_wdata;
    exp_req.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input int h, input int l);
    @(posedge clk);
    #1 rx_data = b;
    rx_finish = 1'b1;
    repeat (h) @(posedge clk);
    #1 rx_finish = 1'b0;
    repeat (l) @(posedge clk);
  endtask

  // Strobe edge lands exactly gap edges after the previous one.
  task automatic strobe_at(input logic [7:0] b, input int gap);
    repeat (gap - 1) @(posedge clk);
    #1 rx_data = b;
    rx_finish = 1'b1;
    @(posedge clk);
    #1 rx_finish = 1'b0;
  endtask

  task automatic send_packet(input logic w, input logic [23:0] a,
                             input logic [15:0] d, input logic fast_last);
    bq_t q;
    q = mk(w, a, d);
    push_req(w, a, d);
    foreach (q[i]) begin
      if (fast_last && i == q.size() - 1) send_byte(q[i], 1, 0);
      else send_byte(q[i], $urandom_range(1, 30), $urandom_range(0, 30));
    end
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((exp_req.size() != 0 || exp_err.size() != 0 || req_valid) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    check_eq({name, "_drain"}, k < 3000, 1);
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!req_valid && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq({name, "_valid"}, req_valid, 1);
  endtask

  initial begin
    bq_t q;
    int k;
    logic [7:0] b;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("rst_req_valid", req_valid, 0);
    check_eq("rst_err_valid", err_valid, 0);
    check_eq("rst_req_write", req_write, 0);
    check_eq("rst_req_addr", req_addr, 0);
    check_eq("rst_req_wdata", req_wdata, 0);
    check_eq("rst_err_code", err_code, 0);

    // Write with ready held high: a single valid cycle
    req_ready = 1'b1;
    vcnt = 0;
    send_packet(1'b1, 24'h123456, 16'hABCD, 1'b0);
    wait_done("write");
    check_eq("write_valid_cycles", vcnt, 1);

    // Read held off for 20 cycles
    req_ready = 1'b0;
    vcnt = 0;
    send_packet(1'b0, 24'h0001FF, 16'h0000, 1'b1);
    repeat (20) @(posedge clk);
    #1 req_ready = 1'b1;
    @(posedge clk);
    #1 check_eq("bp_valid_drop", req_valid, 0);
    check_eq("bp_valid_cycles", vcnt, 21);
    wait_done("backpressure");

    // Bad command, then a read still works
    exp_err.push_back(2'd1);
    send_byte(8'h41, 5, 5);
    send_packet(1'b0, 24'h000010, 16'h0000, 1'b0);
    wait_done("badcmd");

    // Random traffic with random backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h57 || b == 8'h52) b = 8'h00;
        exp_err.push_back(2'd1);
        send_byte(b, $urandom_range(1, 30), $urandom_range(0, 30));
      end else begin
        send_packet(1'($urandom_range(0, 1)), 24'($urandom),
                    16'($urandom), 1'($urandom_range(0, 1)));
      end
      wait_done("random");
    end
    @(posedge clk);
    rand_ready = 1'b0;
    #1 req_ready = 1'b1;

    // Strobes exactly TO edges apart still win over the timeout
    q = mk(1'b0, 24'h00ABCD, 16'h0000);
    push_req(1'b0, 24'h00ABCD, 16'h0000);
    strobe_at(q[0], 1);
    for (int i = 1; i < q.size(); i++) strobe_at(q[i], TO);
    wait_done("gap_boundary");

    // Timeout: error pulse TO edges after the last strobe
    exp_err.push_back(2'd2);
    strobe_at(8'h57, 1);
    strobe_at(8'h12, 3);
    k = 0;
    while (!err_valid && k < TO + 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq("timeout_latency", k, TO);
    wait_done("timeout");
    send_packet(1'b1, 24'h0BEEF0, 16'h5A5A, 1'b0);
    wait_done("after_timeout");

    // Overrun while pending keeps the request
    req_ready = 1'b0;
    send_packet(1'b1, 24'hC0FFEE, 16'h1234, 1'b0);
    wait_valid("overrun");
    exp_err.push_back(2'd3);
    send_byte(8'h41, 3, 2);
    #1 check_eq("overrun_still_valid", req_valid, 1);
    check_eq("overrun_addr", req_addr, 24'hC0FFEE);
    req_ready = 1'b1;
    wait_done("overrun");

    // Overrun on the accept cycle
    req_ready = 1'b0;
    send_packet(1'b0, 24'h777777, 16'h0000, 1'b0);
    wait_valid("overrun_accept");
    exp_err.push_back(2'd3);
    @(posedge clk);
    #1 rx_data = 8'h41;
    rx_finish = 1'b1;
    req_ready = 1'b1;
    @(posedge clk);
    #1 rx_finish = 1'b0;
    req_ready = 1'b0;
    check_eq("overrun_accept_idle", req_valid, 0);
    wait_done("overrun_accept");

    // Reset drops a pending request; held flag is not a byte
    send_packet(1'b0, 24'h0A0B0C, 16'h0000, 1'b0);
    wait_valid("reset_drop");
    @(posedge clk);
    #1 rx_data = 8'h41;
    rx_finish = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_req.delete();
    last_wdata = '0;
    check_eq("reset_drop_valid", req_valid, 0);
    check_eq("reset_addr", req_addr, 0);
    repeat (5) @(posedge clk);
    #1 rx_finish = 1'b0;
    check_eq("reset_no_strobe_err", err_valid, 0);
    check_eq("reset_still_idle", req_valid, 0);
    req_ready = 1'b1;
    send_packet(1'b0, 24'h000042, 16'h0000, 1'b0);
    wait_done("after_reset");

`ifdef UART_CMD_CHECKSUM_EN
    push_req(1'b0, 24'h000001, 16'h0000);
    send_byte(8'h52, 4, 4);
    send_byte(8'h00, 4, 4);
    send_byte(8'h00, 4, 4);
    send_byte(8'h01, 4, 4);
    send_byte(8'h53, 4, 4);
    wait_done("csum_ok");
    exp_err.push_back(2'd0);
    vcnt = 0;
    send_byte(8'h52, 4, 4);
    send_byte(8'h00, 4, 4);
    send_byte(8'h00, 4, 4);
    send_byte(8'h01, 4, 4);
    send_byte(8'h54, 4, 4);
    wait_done("csum_bad");
    repeat (5) @(posedge clk);
    check_eq("csum_bad_no_req", vcnt, 0);
`endif

    repeat (10) @(posedge clk);
    check_eq("req_queue_empty", exp_req.size(), 0);
    check_eq("err_queue_empty", exp_err.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
